// File: rtl/hazard_pkg.sv
// Shared types and encodings for the execute-stage hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LONG_OP = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SEL_REG = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

  localparam logic [WB_W-1:0] WB_NONE = 2'b00;
  localparam logic [WB_W-1:0] WB_ALU  = 2'b01;
  localparam logic [WB_W-1:0] WB_LOAD = 2'b10;
  localparam logic [WB_W-1:0] WB_RSVD = 2'b11;

  localparam logic [CMD_W-1:0] MUL_CMD_DEF = 4'b1000;
  localparam logic [CMD_W-1:0] DIV_CMD_DEF = 4'b1001;

  localparam int unsigned MUL_CYCLES_DEF = 3;
  localparam int unsigned DIV_CYCLES_DEF = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/forward_select.sv
// One forwarding-mux select: MEMORY ALU result beats WRITEBACK result, r0 never forwards.
module forward_select
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] dest_mem_i,
  input  logic [WB_W-1:0]  wb_mem_i,
  input  logic [REG_W-1:0] dest_wb_i,
  input  logic [WB_W-1:0]  wb_wb_i,
  output logic [SEL_W-1:0] sel_o
);

  logic mem_writes;
  logic wb_writes;
  logic src_live;

  // Load data is not available in MEMORY; only an ALU result there can forward.
  always_comb begin
    mem_writes = 1'b0;
    wb_writes  = 1'b0;
    unique case (wb_mem_i)
      WB_ALU:                    mem_writes = 1'b1;
      WB_NONE, WB_LOAD, WB_RSVD: mem_writes = 1'b0;
      default:                   mem_writes = 1'b0;
    endcase
    unique case (wb_wb_i)
      WB_ALU, WB_LOAD:  wb_writes = 1'b1;
      WB_NONE, WB_RSVD: wb_writes = 1'b0;
      default:          wb_writes = 1'b0;
    endcase
  end

  assign src_live = (src_i != '0);

  always_comb begin
    sel_o = SEL_REG;
    if (src_live && mem_writes && (src_i == dest_mem_i)) begin
      sel_o = SEL_MEM;
    end else if (src_live && wb_writes && (src_i == dest_wb_i)) begin
      sel_o = SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Execute-stage forwarding, load-use stall and MULT/DIV sequencing, with a
// saturating stall-cycle counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter logic [CMD_W-1:0] MUL_CMD    = MUL_CMD_DEF,
  parameter logic [CMD_W-1:0] DIV_CMD    = DIV_CMD_DEF,
  parameter int unsigned      MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned      DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic               clock2,
  input  logic               reset,
  input  logic [REG_W-1:0]   source1_EXECUTE,
  input  logic [REG_W-1:0]   source2_EXECUTE,
  input  logic [REG_W-1:0]   store_source_EXECUTE,
  input  logic [REG_W-1:0]   source1_DECODE,
  input  logic [REG_W-1:0]   source2_DECODE,
  input  logic [REG_W-1:0]   destination_EXECUTE,
  input  logic               MEMORY_READ_EXECUTE,
  input  logic [CMD_W-1:0]   EXECUTE_command,
  input  logic [REG_W-1:0]   destination_MEMORY,
  input  logic [REG_W-1:0]   destination_WRITEBACK,
  input  logic [WB_W-1:0]    WRITEBACK_MEMORY,
  input  logic [WB_W-1:0]    WRITEBACK_WRITEBACK,
  output logic [SEL_W-1:0]   input1_select,
  output logic [SEL_W-1:0]   input2_select,
  output logic [SEL_W-1:0]   store_select,
  output logic               hold_PC_IF_ID,
  output logic               hold_ID_EX,
  output logic               bubble_ID_EX,
  output logic               bubble_EX_MEM,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count
);

  localparam int unsigned MAX_CYC = max_u(MUL_CYCLES, DIV_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  // The trigger cycle is itself frozen, so the counter starts at N-2.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic is_mul;
  logic is_div;
  logic long_cmd;
  logic freeze;
  logic load_use;
  logic hold_pc;

  forward_select u_fwd_op1 (
    .src_i      (source1_EXECUTE),
    .dest_mem_i (destination_MEMORY),
    .wb_mem_i   (WRITEBACK_MEMORY),
    .dest_wb_i  (destination_WRITEBACK),
    .wb_wb_i    (WRITEBACK_WRITEBACK),
    .sel_o      (input1_select)
  );

  forward_select u_fwd_op2 (
    .src_i      (source2_EXECUTE),
    .dest_mem_i (destination_MEMORY),
    .wb_mem_i   (WRITEBACK_MEMORY),
    .dest_wb_i  (destination_WRITEBACK),
    .wb_wb_i    (WRITEBACK_WRITEBACK),
    .sel_o      (input2_select)
  );

  forward_select u_fwd_store (
    .src_i      (store_source_EXECUTE),
    .dest_mem_i (destination_MEMORY),
    .wb_mem_i   (WRITEBACK_MEMORY),
    .dest_wb_i  (destination_WRITEBACK),
    .wb_wb_i    (WRITEBACK_WRITEBACK),
    .sel_o      (store_select)
  );

  assign is_mul   = (EXECUTE_command == MUL_CMD);
  assign is_div   = (EXECUTE_command == DIV_CMD);
  assign long_cmd = is_mul || is_div;

  // Long-operation sequencer; the trigger is ignored in LONG_OP so an op cannot re-arm itself.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    freeze  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (long_cmd) begin
          freeze  = 1'b1;
          state_d = LONG_OP;
          count_d = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      LONG_OP: begin
        if (count_q != '0) begin
          freeze  = 1'b1;
          count_d = count_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        count_d = '0;
      end
    endcase
  end

  // A load feeding DECODE stalls one cycle unless the freeze already holds the front end.
  assign load_use = MEMORY_READ_EXECUTE
                 && (destination_EXECUTE != '0)
                 && ((destination_EXECUTE == source1_DECODE) || (destination_EXECUTE == source2_DECODE))
                 && !freeze;

  assign hold_pc       = freeze || load_use;
  assign hold_PC_IF_ID = hold_pc;
  assign hold_ID_EX    = freeze;
  assign bubble_ID_EX  = load_use;
  assign bubble_EX_MEM = freeze;

  always_comb begin
    stall_d = stall_q;
    if (hold_pc && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clock2) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= '0;
      busy_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d == LONG_OP);
      stall_q <= stall_d;
    end
  end

  assign busy        = busy_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a cycle-level reference model
// queues expected outputs, a negedge monitor compares them.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic        clock2 = 1'b0;
  logic        reset;
  logic [4:0]  source1_EXECUTE, source2_EXECUTE, store_source_EXECUTE;
  logic [4:0]  source1_DECODE, source2_DECODE, destination_EXECUTE;
  logic        MEMORY_READ_EXECUTE;
  logic [3:0]  EXECUTE_command;
  logic [4:0]  destination_MEMORY, destination_WRITEBACK;
  logic [1:0]  WRITEBACK_MEMORY, WRITEBACK_WRITEBACK;
  logic [1:0]  input1_select, input2_select, store_select;
  logic        hold_PC_IF_ID, hold_ID_EX, bubble_ID_EX, bubble_EX_MEM, busy;
  logic [15:0] stall_count;

  always #5 clock2 = ~clock2;

  hazard_controller dut (
    .clock2               (clock2),
    .reset                (reset),
    .source1_EXECUTE      (source1_EXECUTE),
    .source2_EXECUTE      (source2_EXECUTE),
    .store_source_EXECUTE (store_source_EXECUTE),
    .source1_DECODE       (source1_DECODE),
    .source2_DECODE       (source2_DECODE),
    .destination_EXECUTE  (destination_EXECUTE),
    .MEMORY_READ_EXECUTE  (MEMORY_READ_EXECUTE),
    .EXECUTE_command      (EXECUTE_command),
    .destination_MEMORY   (destination_MEMORY),
    .destination_WRITEBACK(destination_WRITEBACK),
    .WRITEBACK_MEMORY     (WRITEBACK_MEMORY),
    .WRITEBACK_WRITEBACK  (WRITEBACK_WRITEBACK),
    .input1_select        (input1_select),
    .input2_select        (input2_select),
    .store_select         (store_select),
    .hold_PC_IF_ID        (hold_PC_IF_ID),
    .hold_ID_EX           (hold_ID_EX),
    .bubble_ID_EX         (bubble_ID_EX),
    .bubble_EX_MEM        (bubble_EX_MEM),
    .busy                 (busy),
    .stall_count          (stall_count)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] s1e, s2e, sse, s1d, s2d, de;
    logic       mre;
    logic [3:0] cmd;
    logic [4:0] dm, dw;
    logic [1:0] wm, ww;
  } in_t;

  typedef struct packed {
    logic [1:0]  s1, s2, ss;
    logic        hpc, hidex, bidex, bexm, busy;
    logic [15:0] stall;
  } exp_t;

  in_t  cur;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: position of the current long op inside its N-cycle window.
  bit   in_op = 1'b0;
  int   pos   = 0;
  int   n_cur = 0;
  int   stall_tot = 0;

  function automatic void chk(input string n, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
    end
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] src, input logic [4:0] dm, input logic [1:0] wm,
                                     input logic [4:0] dw, input logic [1:0] ww);
    if (src == 5'd0) return 2'b00;
    if (src == dm && wm == 2'b01) return 2'b01;
    if (src == dw && (ww == 2'b01 || ww == 2'b10)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    exp_t e;
    bit   lng, frz, lu;
    @(posedge clock2);
    #1;
    reset                 = cur.rst;
    source1_EXECUTE       = cur.s1e;
    source2_EXECUTE       = cur.s2e;
    store_source_EXECUTE  = cur.sse;
    source1_DECODE        = cur.s1d;
    source2_DECODE        = cur.s2d;
    destination_EXECUTE   = cur.de;
    MEMORY_READ_EXECUTE   = cur.mre;
    EXECUTE_command       = cur.cmd;
    destination_MEMORY    = cur.dm;
    destination_WRITEBACK = cur.dw;
    WRITEBACK_MEMORY      = cur.wm;
    WRITEBACK_WRITEBACK   = cur.ww;

    lng = (cur.cmd == 4'b1000) || (cur.cmd == 4'b1001);
    if (!in_op && lng) begin
      in_op = 1'b1;
      pos   = 1;
      n_cur = (cur.cmd == 4'b1001) ? 8 : 3;
    end
    frz = in_op && (pos < n_cur);
    lu  = cur.mre && (cur.de != 5'd0) && (cur.de == cur.s1d || cur.de == cur.s2d) && !frz;

    e.s1    = fwd(cur.s1e, cur.dm, cur.wm, cur.dw, cur.ww);
    e.s2    = fwd(cur.s2e, cur.dm, cur.wm, cur.dw, cur.ww);
    e.ss    = fwd(cur.sse, cur.dm, cur.wm, cur.dw, cur.ww);
    e.hpc   = frz || lu;
    e.hidex = frz;
    e.bidex = lu;
    e.bexm  = frz;
    e.busy  = in_op && (pos >= 2);
    e.stall = (stall_tot > 65535) ? 16'hFFFF : 16'(stall_tot);
    exp_q.push_back(e);

    if (cur.rst) begin
      in_op     = 1'b0;
      stall_tot = 0;
    end else begin
      if (e.hpc) stall_tot++;
      if (in_op) begin
        pos++;
        if (pos > n_cur) in_op = 1'b0;
      end
    end
  endtask

  always @(negedge clock2) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("input1_select", 16'(input1_select), 16'(e.s1));
      chk("input2_select", 16'(input2_select), 16'(e.s2));
      chk("store_select",  16'(store_select),  16'(e.ss));
      chk("hold_PC_IF_ID", 16'(hold_PC_IF_ID), 16'(e.hpc));
      chk("hold_ID_EX",    16'(hold_ID_EX),    16'(e.hidex));
      chk("bubble_ID_EX",  16'(bubble_ID_EX),  16'(e.bidex));
      chk("bubble_EX_MEM", 16'(bubble_EX_MEM), 16'(e.bexm));
      chk("busy",          16'(busy),          16'(e.busy));
      chk("stall_count",   stall_count,        e.stall);
    end
  end

  task automatic do_reset();
    cur = '0;
    cur.rst = 1'b1;
    step();
    cur.rst = 1'b0;
  endtask

  initial begin
    int r;
    cur = '0;
    reset = 1'b1;
    {source1_EXECUTE, source2_EXECUTE, store_source_EXECUTE} = '0;
    {source1_DECODE, source2_DECODE, destination_EXECUTE} = '0;
    MEMORY_READ_EXECUTE = 1'b0;
    EXECUTE_command = '0;
    {destination_MEMORY, destination_WRITEBACK} = '0;
    {WRITEBACK_MEMORY, WRITEBACK_WRITEBACK} = '0;
    repeat (2) @(posedge clock2);

    // Reset state, then forwarding priority MEM over WB
    cur = '0; step();
    cur.s1e = 5'd5; cur.dm = 5'd5; cur.wm = 2'b01; cur.dw = 5'd5; cur.ww = 2'b01; step();
    cur.wm = 2'b00; step();
    cur.ww = 2'b10; cur.s2e = 5'd5; step();
    cur.ww = 2'b11; step();
    // r0 and load-in-MEMORY are never forwarded from MEMORY
    cur = '0; step();
    cur.sse = 5'd7; cur.dm = 5'd7; cur.wm = 2'b10; step();
    cur.dw = 5'd7; cur.ww = 2'b10; step();

    // Load-use on source2_DECODE, then on r0 (no stall)
    cur = '0; cur.mre = 1'b1; cur.de = 5'd3; cur.s2d = 5'd3; step();
    cur = '0; step();
    cur.mre = 1'b1; cur.s1d = 5'd0; cur.de = 5'd0; step();
    cur = '0; step();

    // MULT, then DIV with exact stall count
    cur.cmd = 4'b1000; repeat (3) step();
    cur = '0; step();
    do_reset();
    cur.cmd = 4'b1001; repeat (8) step();
    cur = '0; step();
    @(negedge clock2);
    chk("div_stall_total", stall_count, 16'd7);

    // Back-to-back MULT then DIV, with a load-use hazard presented during the freeze
    cur = '0; cur.cmd = 4'b1000; repeat (3) step();
    cur.cmd = 4'b1001; cur.mre = 1'b1; cur.de = 5'd4; cur.s1d = 5'd4; repeat (8) step();
    cur = '0; step();

    // Reset when count has reached 3 inside a DIV
    do_reset();
    cur.cmd = 4'b1001; repeat (4) step();
    cur.rst = 1'b1; step();
    cur = '0; step();
    @(negedge clock2);
    chk("abort_busy",  16'(busy), 16'd0);
    chk("abort_stall", stall_count, 16'd0);
    chk("abort_hold",  16'(hold_PC_IF_ID), 16'd0);

    // Saturation of the stall counter
    do_reset();
    cur.mre = 1'b1; cur.de = 5'd3; cur.s1d = 5'd3;
    repeat (70000) step();
    @(negedge clock2);
    chk("sat_value", stall_count, 16'hFFFF);
    step();
    @(negedge clock2);
    chk("sat_hold", stall_count, 16'hFFFF);

    // Randomized traffic with occasional resets and long ops
    do_reset();
    repeat (3000) begin
      cur.rst = ($urandom_range(0, 49) == 0);
      cur.s1e = 5'($urandom_range(0, 3));
      cur.s2e = 5'($urandom_range(0, 3));
      cur.sse = 5'($urandom_range(0, 3));
      cur.s1d = 5'($urandom_range(0, 3));
      cur.s2d = 5'($urandom_range(0, 3));
      cur.de  = 5'($urandom_range(0, 3));
      cur.dm  = 5'($urandom_range(0, 3));
      cur.dw  = 5'($urandom_range(0, 3));
      cur.wm  = 2'($urandom_range(0, 3));
      cur.ww  = 2'($urandom_range(0, 3));
      cur.mre = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      if (r == 0)      cur.cmd = 4'b1000;
      else if (r == 1) cur.cmd = 4'b1001;
      else             cur.cmd = 4'($urandom_range(0, 7));
      step();
    end

    cur = '0; step();
    repeat (2) @(negedge clock2);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the execute stage. Each cycle it generates the three forwarding-mux selects (ALU operand 1, ALU operand 2, store data) from register-number comparisons against the MEMORY and WRITEBACK stages. It detects load-use hazards against the instruction in DECODE and sequences multi-cycle MULT/DIV commands by freezing the front of the pipeline and injecting bubbles into EX/MEM. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MUL_CMD, 4'b1000, EXECUTE_command code for multiply
- DIV_CMD, 4'b1001, EXECUTE_command code for divide
- MUL_CYCLES, 3, cycles a MULT occupies EXECUTE (must be ≥2)
- DIV_CYCLES, 8, cycles a DIV occupies EXECUTE (must be ≥2)

Ports:
- clock2  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- source1_EXECUTE, source2_EXECUTE, store_source_EXECUTE  in  5  register numbers read by the EXECUTE instruction
- source1_DECODE, source2_DECODE  in  5  register numbers read by the DECODE instruction
- destination_EXECUTE  in  5  destination register of the EXECUTE instruction
- MEMORY_READ_EXECUTE  in  1  EXECUTE instruction is a load
- EXECUTE_command  in  4  ALU command in EXECUTE
- destination_MEMORY, destination_WRITEBACK  in  5  destination registers
- WRITEBACK_MEMORY, WRITEBACK_WRITEBACK  in  2  writeback kind: 00 none, 01 ALU result, 10 load data, 11 reserved (treated as none)
- input1_select, input2_select, store_select  out  2  forwarding-mux select: 00 register file, 01 MEMORY forward, 10 WRITEBACK forward
- hold_PC_IF_ID  out  1  hold PC and the IF/ID register
- hold_ID_EX  out  1  hold the ID/EX register
- bubble_ID_EX  out  1  load a NOP into ID/EX
- bubble_EX_MEM  out  1  load a NOP into EX/MEM
- busy  out  1  a long operation is in progress
- stall_count  out  16  saturating count of cycles with hold_PC_IF_ID=1

## Operation
Forwarding is combinational and is evaluated separately for each select output, using the corresponding source register.
- MEMORY match: src≠0, src==destination_MEMORY and WRITEBACK_MEMORY==01. A match gives 01.
- WRITEBACK match: src≠0, src==destination_WRITEBACK and WRITEBACK_WRITEBACK∈{01,10}. A match gives 10.
- MEMORY takes priority over WRITEBACK. With no match the select is 00.
- Register 0 is never forwarded.
- A load in MEMORY (WRITEBACK_MEMORY==10) is never forwarded from MEMORY; the load-use stall covers this case.

Long-operation FSM has two states, RUN and LONG_OP, with a down-counter `count` (width sized for max(MUL_CYCLES, DIV_CYCLES)).
- long = EXECUTE_command∈{MUL_CMD, DIV_CMD}. N = MUL_CYCLES or DIV_CYCLES according to the command.
- RUN with long: the freeze is asserted this cycle. Next state LONG_OP, count←N-2.
- LONG_OP with count≠0: freeze asserted, count←count-1.
- LONG_OP with count==0: freeze deasserted (release cycle). Next state RUN.
- The long-op trigger is not evaluated while in LONG_OP, so the same instruction cannot re-trigger.
- Freeze means hold_PC_IF_ID=1, hold_ID_EX=1 and bubble_EX_MEM=1.
- busy=1 whenever state==LONG_OP.

Load-use hazard:
- Condition: MEMORY_READ_EXECUTE=1, destination_EXECUTE≠0, destination_EXECUTE equals source1_DECODE or source2_DECODE, and the freeze is inactive.
- Response: hold_PC_IF_ID=1 and bubble_ID_EX=1 for one cycle. hold_ID_EX stays 0.
- Freeze takes priority: while the freeze is active, bubble_ID_EX=0.

stall_count increments every cycle in which hold_PC_IF_ID=1 and holds at 16'hFFFF once saturated.

## Timing
- Selects and hold/bubble outputs are combinational from the inputs, state and count. There are no registered outputs other than busy and stall_count.
- A long op occupies EXECUTE for exactly N cycles; EX/MEM captures its result at the edge that ends the release cycle.
- Reset: state=RUN, count=0, stall_count=0, busy=0. Reset during LONG_OP aborts the operation; hold/bubble outputs are 0 in the first cycle after reset unless the inputs themselves imply a hazard.
- Two back-to-back long ops: after the release cycle the next op triggers in RUN, with no idle cycle between them.

## Structure
- Package `hazard_pkg`: state enum (RUN, LONG_OP); select encodings SEL_REG, SEL_MEM, SEL_WB; WRITEBACK kind encodings; default MUL/DIV command codes.
- Sub-module `forward_select`: a combinational comparator producing one 2-bit select. Instantiate it three times, for operand 1, operand 2 and store data.

## Test plan
- Forwarding priority: source1_EXECUTE=5, destination_MEMORY=5 with WB_MEM=01, destination_WRITEBACK=5 with WB_WB=01 → input1_select=01. Clear the MEMORY writeback → input1_select=10.
- R0 and load-in-MEM: sources=0 with all destinations=0 → all selects 00. store_source=7, destination_MEMORY=7, WB_MEM=10 → store_select=00.
- Load-use: load to r3 in EXECUTE, source2_DECODE=3 → exactly one cycle with hold_PC_IF_ID=1, bubble_ID_EX=1, hold_ID_EX=0, and stall_count increments by 1.
- MULT sequencing with MUL_CYCLES=3: hold/bubble_EX_MEM high for 2 cycles, low in the third, and busy high for 2 cycles. DIV with DIV_CYCLES=8 → 7 frozen cycles and stall_count=7.
- Reset mid-DIV: assert reset at count=3 → next cycle state RUN, busy=0, stall_count=0, all holds 0 (with no long op presented).
- Saturation: 70000 consecutive stall cycles → stall_count=16'hFFFF and holds there.
